cell_reader: RTL
================

// Module: cell_reader
//
// PURPOSE
//   Fetches one complete heap cell (header, car, cdr) from the memory block's
//   read port given a pointer to the cell's header word. Sits directly upstream
//   of memory on the read side; evaluator/printer stages issue start + ptr and
//   receive the decoded cell. Cell layout: header at p, car at p-1, cdr at p-2.
//   Reads are pipelined back-to-back: one request per cycle.
//
// PARAMETERS
//   MemorySize  256  number of 16-bit words in memory; valid header ptr range
//                    is [2, MemorySize-1]
//
// PORTS
//   clk             in   1   single clock; all logic on posedge
//   rst             in   1   synchronous, active-high reset
//   start           in   1   request a cell fetch; sampled only when busy=0
//   ptr_in          in   16  address of the cell header word
//   busy            out  1   fetch in progress; start ignored while high
//   done            out  1   one-cycle pulse: cell outputs valid
//   err             out  1   one-cycle pulse instead of done: ptr out of range
//   type_out        out  15  header[14:0] (cell type tag)
//   car_out         out  16  word at p-1
//   cdr_out         out  16  word at p-2
//   mem_req         out  1   to memory.req
//   mem_addr        out  16  to memory.addr_in
//   mem_data_ready  in   1   from memory.data_ready
//   mem_data        in   16  from memory.data_out
//
// BEHAVIOUR
//   - Reset: busy=0, done=0, err=0, mem_req=0, mem_addr=0, type_out=0,
//     car_out=0, cdr_out=0, issue/capture counters=0, state Idle.
//   - Memory contract: req high in cycle n -> data_ready=1, data_out=mem[addr]
//     in cycle n+1.
//   - States: Idle -> Issue (3 cycles) -> Drain -> Done -> Idle; Idle -> Err -> Idle.
//   - Idle: start=1 with ptr_in in [2, MemorySize-1] latches ptr, busy=1, -> Issue.
//     start=1 with ptr_in<2 or ptr_in>=MemorySize: no mem_req; err=1 next cycle
//     for one cycle, busy stays 0, outputs unchanged.
//   - Timing (start sampled at edge 0): mem_req=1 in cycles 1,2,3 with mem_addr
//     p, p-1, p-2; data_ready in cycles 2,3,4; done=1 in cycle 5. Latency 5.
//   - Capture counter (0..3) advances only on mem_data_ready=1 while busy:
//     0 -> type_out=mem_data[14:0], 1 -> car_out, 2 -> cdr_out. Header bit 15
//     is dropped. data_ready while Idle is ignored.
//   - Done (cycle 5): done=1, busy=0; start accepted in this cycle (back-to-back).
//     type/car/cdr outputs hold until the next fetch's captures overwrite them.
//   - mem_req deasserts after the third issue; never more than 3 reqs per fetch.
//   - Address arithmetic 16-bit unsigned; range check guarantees no underflow.
//   - rst mid-fetch: all state and outputs to reset values on that edge;
//     in-flight memory responses that arrive after reset are ignored.
//   - done and err never high in the same cycle.
//
// TESTING
//   - Preloaded mem[3]={0,TYPE_NUMBER}, mem[2]=16'h789A, mem[1]=LISP_NIL; start,
//     ptr_in=3 -> mem_addr 3,2,1 in cycles 1-3; done in cycle 5, type_out=
//     TYPE_NUMBER, car_out=16'h789A, cdr_out=LISP_NIL.
//   - ptr_in=1 and ptr_in=256 -> err pulses once, mem_req never rises, busy=0.
//   - Two fetches back-to-back (start held across done cycle), second ptr=6
//     after a cons write at heap 4..6 -> second done 5 cycles after first done,
//     fields match the written cdr/car/type.
//   - start pulsed during busy with different ptr -> ignored; results reflect
//     first ptr only, exactly 3 mem_req cycles.
//   - rst asserted in cycle 3 of a fetch -> next cycle all outputs 0, no done;
//     a fresh start after reset fetches correctly.
//   - mem_data_ready forced high while Idle -> outputs unchanged, no done.

Source files
------------

// File: rtl/cell_mem_if.sv
// Read-port bundle between the cell reader and the heap memory.
// master: req/addr out, data_ready/data in; slave is the memory side.
interface cell_mem_if;
  logic        req;
  logic [15:0] addr;
  logic        data_ready;
  logic [15:0] data;

  modport master (
    output req,
    output addr,
    input  data_ready,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output data_ready,
    output data
  );
endinterface

// File: rtl/cell_reader.sv
// Fetches a heap cell (header at p, car at p-1, cdr at p-2) in 5 cycles.
// Ports: clk, rst, start/ptr_in request, busy/done/err status,
// type_out/car_out/cdr_out result, mem read port (cell_mem_if.master).
module cell_reader #(
  parameter int MemorySize = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ptr_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] type_out,
  output logic [15:0] car_out,
  output logic [15:0] cdr_out,
  cell_mem_if.master  mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [1:0] issue_cnt;
  logic [1:0] cap_cnt;
  logic       in_range;
  logic       accept;
  logic       take;

  // Lower bound 2 keeps p-2 from underflowing.
  always_comb begin
    state_n  = state;
    in_range = (ptr_in >= 16'd2) &&
               (32'(ptr_in) < 32'(MemorySize));
    busy     = (state == S_ISSUE) ||
               (state == S_DRAIN);
    done     = (state == S_DONE);
    err      = (state == S_ERR);
    accept   = start && in_range &&
               ((state == S_IDLE) ||
                (state == S_DONE));
    take     = busy && mem.data_ready &&
               (cap_cnt != 2'd3);
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_n = in_range ? S_ISSUE : S_ERR;
        else
          state_n = S_IDLE;
      end
      S_ISSUE: begin
        if (issue_cnt == 2'd3)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (take && cap_cnt == 2'd2)
          state_n = S_DONE;
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_cnt <= 2'd0;
      cap_cnt   <= 2'd0;
      mem.req   <= 1'b0;
      mem.addr  <= 16'd0;
      type_out  <= 15'd0;
      car_out   <= 16'd0;
      cdr_out   <= 16'd0;
    end else begin
      state <= state_n;
      // Address walks p, p-1, p-2 on successive issue cycles.
      if (accept) begin
        mem.req   <= 1'b1;
        mem.addr  <= ptr_in;
        issue_cnt <= 2'd1;
        cap_cnt   <= 2'd0;
      end else if (state == S_ISSUE) begin
        if (issue_cnt == 2'd3) begin
          mem.req <= 1'b0;
        end else begin
          mem.addr  <= mem.addr - 16'd1;
          issue_cnt <= issue_cnt + 2'd1;
        end
      end
      if (take) begin
        unique case (1'b1)
          (cap_cnt == 2'd0): type_out <= mem.data[14:0];
          (cap_cnt == 2'd1): car_out  <= mem.data;
          (cap_cnt == 2'd2): cdr_out  <= mem.data;
          default: ;
        endcase
        cap_cnt <= cap_cnt + 2'd1;
      end
    end
  end

endmodule
